// File: rtl/reservation_station.sv
// Reservation station for ALU-bound instructions.
// Holds dispatched instructions until both source operands are available,
// snoops the ALU and load/store result buses for the missing operands,
// and hands one ready instruction per cycle to the ALU.
module reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4,
  parameter int TYPE_W  = 6,
  parameter int XLEN    = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              dispatch_en_in,
  input  logic [TYPE_W-1:0] inst_type_in,
  input  logic [XLEN-1:0]   vj_in,
  input  logic [ROB_W-1:0]  qj_in,
  input  logic [XLEN-1:0]   vk_in,
  input  logic [ROB_W-1:0]  qk_in,
  input  logic [XLEN-1:0]   A_in,
  input  logic [ROB_W-1:0]  dest_in,
  input  logic [XLEN-1:0]   pc_in,
  output logic              rs_full_out,
  input  logic              cdb_alu_en_in,
  input  logic [ROB_W-1:0]  cdb_alu_tag_in,
  input  logic [XLEN-1:0]   cdb_alu_data_in,
  input  logic              cdb_lsb_en_in,
  input  logic [ROB_W-1:0]  cdb_lsb_tag_in,
  input  logic [XLEN-1:0]   cdb_lsb_data_in,
  output logic              alu_en_out,
  output logic [TYPE_W-1:0] alu_inst_type_out,
  output logic [XLEN-1:0]   alu_vj_out,
  output logic [XLEN-1:0]   alu_vk_out,
  output logic [XLEN-1:0]   alu_A_out,
  output logic [XLEN-1:0]   alu_pc_out,
  output logic [ROB_W-1:0]  alu_dest_out
);

  localparam int IDX_W = $clog2(RS_SIZE);

  // Entry storage
  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [TYPE_W-1:0]  instType_q [RS_SIZE];
  logic [TYPE_W-1:0]  instType_d [RS_SIZE];
  logic [XLEN-1:0]    vj_q [RS_SIZE];
  logic [XLEN-1:0]    vj_d [RS_SIZE];
  logic [ROB_W-1:0]   qj_q [RS_SIZE];
  logic [ROB_W-1:0]   qj_d [RS_SIZE];
  logic [XLEN-1:0]    vk_q [RS_SIZE];
  logic [XLEN-1:0]    vk_d [RS_SIZE];
  logic [ROB_W-1:0]   qk_q [RS_SIZE];
  logic [ROB_W-1:0]   qk_d [RS_SIZE];
  logic [XLEN-1:0]    imm_q [RS_SIZE];
  logic [XLEN-1:0]    imm_d [RS_SIZE];
  logic [ROB_W-1:0]   dest_q [RS_SIZE];
  logic [ROB_W-1:0]   dest_d [RS_SIZE];
  logic [XLEN-1:0]    pc_q [RS_SIZE];
  logic [XLEN-1:0]    pc_d [RS_SIZE];

  // Registered issue port
  logic              aluEn_q, aluEn_d;
  logic [TYPE_W-1:0] aluType_q, aluType_d;
  logic [XLEN-1:0]   aluVj_q, aluVj_d;
  logic [XLEN-1:0]   aluVk_q, aluVk_d;
  logic [XLEN-1:0]   aluA_q, aluA_d;
  logic [XLEN-1:0]   aluPc_q, aluPc_d;
  logic [ROB_W-1:0]  aluDest_q, aluDest_d;

  logic             issueFound;
  logic [IDX_W-1:0] issueIdx;
  logic [IDX_W-1:0] allocIdx;

  // A waiting tag is satisfied by either bus; tag 0 never matches.
  function automatic logic cdbHit(input logic [ROB_W-1:0] tag);
    return (tag != '0) &&
           ((cdb_alu_en_in && (cdb_alu_tag_in == tag)) ||
            (cdb_lsb_en_in && (cdb_lsb_tag_in == tag)));
  endfunction

  // The ALU bus takes precedence when both buses carry the same tag.
  function automatic logic [XLEN-1:0] cdbData(input logic [ROB_W-1:0] tag);
    if (cdb_alu_en_in && (cdb_alu_tag_in == tag)) return cdb_alu_data_in;
    return cdb_lsb_data_in;
  endfunction

  assign rs_full_out = &busy_q;

  // Lowest-index ready entry, judged only on start-of-cycle register state
  always_comb begin
    issueFound = 1'b0;
    issueIdx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0)) begin
        issueFound = 1'b1;
        issueIdx   = IDX_W'(i);
      end
    end
  end

  // Lowest-index free entry; meaningful only when the station is not full
  always_comb begin
    allocIdx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) allocIdx = IDX_W'(i);
    end
  end

  // Next-state: flush, else operand wakeup, issue and allocation together
  always_comb begin
    busy_d     = busy_q;
    instType_d = instType_q;
    vj_d       = vj_q;
    qj_d       = qj_q;
    vk_d       = vk_q;
    qk_d       = qk_q;
    imm_d      = imm_q;
    dest_d     = dest_q;
    pc_d       = pc_q;
    aluEn_d    = 1'b0;
    aluType_d  = aluType_q;
    aluVj_d    = aluVj_q;
    aluVk_d    = aluVk_q;
    aluA_d     = aluA_q;
    aluPc_d    = aluPc_q;
    aluDest_d  = aluDest_q;

    if (clear_in) begin
      busy_d = '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i]) begin
          if (cdbHit(qj_q[i])) begin
            vj_d[i] = cdbData(qj_q[i]);
            qj_d[i] = '0;
          end
          if (cdbHit(qk_q[i])) begin
            vk_d[i] = cdbData(qk_q[i]);
            qk_d[i] = '0;
          end
        end
      end

      if (issueFound) begin
        aluEn_d          = 1'b1;
        aluType_d        = instType_q[issueIdx];
        aluVj_d          = vj_q[issueIdx];
        aluVk_d          = vk_q[issueIdx];
        aluA_d           = imm_q[issueIdx];
        aluPc_d          = pc_q[issueIdx];
        aluDest_d        = dest_q[issueIdx];
        busy_d[issueIdx] = 1'b0;
      end

      // The slot chosen here was free at cycle start, so it never collides
      // with the entry being issued in the same cycle.
      if (dispatch_en_in && !rs_full_out) begin
        busy_d[allocIdx]     = 1'b1;
        instType_d[allocIdx] = inst_type_in;
        imm_d[allocIdx]      = A_in;
        dest_d[allocIdx]     = dest_in;
        pc_d[allocIdx]       = pc_in;
        if (cdbHit(qj_in)) begin
          vj_d[allocIdx] = cdbData(qj_in);
          qj_d[allocIdx] = '0;
        end else begin
          vj_d[allocIdx] = vj_in;
          qj_d[allocIdx] = qj_in;
        end
        if (cdbHit(qk_in)) begin
          vk_d[allocIdx] = cdbData(qk_in);
          qk_d[allocIdx] = '0;
        end else begin
          vk_d[allocIdx] = vk_in;
          qk_d[allocIdx] = qk_in;
        end
      end
    end
  end

  // State registers; rdy_in low freezes everything
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        instType_q[i] <= '0;
        vj_q[i]       <= '0;
        qj_q[i]       <= '0;
        vk_q[i]       <= '0;
        qk_q[i]       <= '0;
        imm_q[i]      <= '0;
        dest_q[i]     <= '0;
        pc_q[i]       <= '0;
      end
      aluEn_q   <= 1'b0;
      aluType_q <= '0;
      aluVj_q   <= '0;
      aluVk_q   <= '0;
      aluA_q    <= '0;
      aluPc_q   <= '0;
      aluDest_q <= '0;
    end else if (rdy_in) begin
      busy_q     <= busy_d;
      instType_q <= instType_d;
      vj_q       <= vj_d;
      qj_q       <= qj_d;
      vk_q       <= vk_d;
      qk_q       <= qk_d;
      imm_q      <= imm_d;
      dest_q     <= dest_d;
      pc_q       <= pc_d;
      aluEn_q    <= aluEn_d;
      aluType_q  <= aluType_d;
      aluVj_q    <= aluVj_d;
      aluVk_q    <= aluVk_d;
      aluA_q     <= aluA_d;
      aluPc_q    <= aluPc_d;
      aluDest_q  <= aluDest_d;
    end
  end

  assign alu_en_out        = aluEn_q;
  assign alu_inst_type_out = aluType_q;
  assign alu_vj_out        = aluVj_q;
  assign alu_vk_out        = aluVk_q;
  assign alu_A_out         = aluA_q;
  assign alu_pc_out        = aluPc_q;
  assign alu_dest_out      = aluDest_q;

endmodule

// File: tb/tb_reservation_station.sv
// Testbench for reservation_station: directed scenarios plus a randomized
// run, all compared against a behavioural model of the station.
module tb_reservation_station;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_in;
  logic        dispatch_en_in;
  logic [5:0]  inst_type_in;
  logic [31:0] vj_in, vk_in, A_in, pc_in;
  logic [3:0]  qj_in, qk_in, dest_in;
  logic        rs_full_out;
  logic        cdb_alu_en_in, cdb_lsb_en_in;
  logic [3:0]  cdb_alu_tag_in, cdb_lsb_tag_in;
  logic [31:0] cdb_alu_data_in, cdb_lsb_data_in;
  logic        alu_en_out;
  logic [5:0]  alu_inst_type_out;
  logic [31:0] alu_vj_out, alu_vk_out, alu_A_out, alu_pc_out;
  logic [3:0]  alu_dest_out;

  int errors = 0;
  int checks = 0;

  // Reference model: a table of pending instructions plus the last issue
  bit          mBusy [16];
  logic [5:0]  mType [16];
  logic [31:0] mVj [16], mVk [16], mA [16], mPc [16];
  logic [3:0]  mQj [16], mQk [16], mDest [16];
  logic        eEn;
  logic [5:0]  eType;
  logic [31:0] eVj, eVk, eA, ePc;
  logic [3:0]  eDest;

  reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .dispatch_en_in(dispatch_en_in), .inst_type_in(inst_type_in),
    .vj_in(vj_in), .qj_in(qj_in), .vk_in(vk_in), .qk_in(qk_in),
    .A_in(A_in), .dest_in(dest_in), .pc_in(pc_in), .rs_full_out(rs_full_out),
    .cdb_alu_en_in(cdb_alu_en_in), .cdb_alu_tag_in(cdb_alu_tag_in),
    .cdb_alu_data_in(cdb_alu_data_in), .cdb_lsb_en_in(cdb_lsb_en_in),
    .cdb_lsb_tag_in(cdb_lsb_tag_in), .cdb_lsb_data_in(cdb_lsb_data_in),
    .alu_en_out(alu_en_out), .alu_inst_type_out(alu_inst_type_out),
    .alu_vj_out(alu_vj_out), .alu_vk_out(alu_vk_out), .alu_A_out(alu_A_out),
    .alu_pc_out(alu_pc_out), .alu_dest_out(alu_dest_out)
  );

  // Free-running clock
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit modelFull();
    for (int i = 0; i < 16; i++) if (!mBusy[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mBusy[i] = 1'b0;
    eEn = 0; eType = '0; eVj = '0; eVk = '0; eA = '0; ePc = '0; eDest = '0;
  endtask

  // Returns {tag, value} after looking at both buses (ALU bus first)
  function automatic logic [35:0] resolve(input logic [3:0] tag, input logic [31:0] val);
    if (tag == 4'd0) return {tag, val};
    if (cdb_alu_en_in && cdb_alu_tag_in == tag) return {4'd0, cdb_alu_data_in};
    if (cdb_lsb_en_in && cdb_lsb_tag_in == tag) return {4'd0, cdb_lsb_data_in};
    return {tag, val};
  endfunction

  task automatic modelStep();
    int iss;
    int fre;
    logic [35:0] r;
    if (!rdy_in) return;
    if (clear_in) begin
      for (int i = 0; i < 16; i++) mBusy[i] = 1'b0;
      eEn = 0;
      return;
    end
    iss = -1;
    fre = -1;
    for (int i = 0; i < 16; i++) begin
      if (iss < 0 && mBusy[i] && mQj[i] == 0 && mQk[i] == 0) iss = i;
      if (fre < 0 && !mBusy[i]) fre = i;
    end
    for (int i = 0; i < 16; i++) begin
      if (mBusy[i]) begin
        r = resolve(mQj[i], mVj[i]); mQj[i] = r[35:32]; mVj[i] = r[31:0];
        r = resolve(mQk[i], mVk[i]); mQk[i] = r[35:32]; mVk[i] = r[31:0];
      end
    end
    eEn = (iss >= 0);
    if (iss >= 0) begin
      eType = mType[iss]; eVj = mVj[iss]; eVk = mVk[iss];
      eA = mA[iss]; ePc = mPc[iss]; eDest = mDest[iss];
      mBusy[iss] = 1'b0;
    end
    if (dispatch_en_in && fre >= 0) begin
      mBusy[fre] = 1'b1; mType[fre] = inst_type_in; mA[fre] = A_in;
      mPc[fre] = pc_in; mDest[fre] = dest_in;
      r = resolve(qj_in, vj_in); mQj[fre] = r[35:32]; mVj[fre] = r[31:0];
      r = resolve(qk_in, vk_in); mQk[fre] = r[35:32]; mVk[fre] = r[31:0];
    end
  endtask

  task automatic setIdle();
    rdy_in = 1; clear_in = 0; dispatch_en_in = 0;
    inst_type_in = '0; vj_in = '0; qj_in = '0; vk_in = '0; qk_in = '0;
    A_in = '0; dest_in = '0; pc_in = '0;
    cdb_alu_en_in = 0; cdb_alu_tag_in = '0; cdb_alu_data_in = '0;
    cdb_lsb_en_in = 0; cdb_lsb_tag_in = '0; cdb_lsb_data_in = '0;
  endtask

  task automatic setDispatch(input logic [5:0] t, input logic [31:0] vj, input logic [3:0] qj,
                             input logic [31:0] vk, input logic [3:0] qk, input logic [31:0] a,
                             input logic [3:0] dest, input logic [31:0] pc);
    dispatch_en_in = 1; inst_type_in = t; vj_in = vj; qj_in = qj; vk_in = vk;
    qk_in = qk; A_in = a; dest_in = dest; pc_in = pc;
  endtask

  // One clock: advance the model with the current inputs, then compare
  task automatic applyStimulus();
    modelStep();
    @(posedge clk_in);
    #1;
    checkOutput("alu_en", 32'(alu_en_out), 32'(eEn));
    checkOutput("alu_type", 32'(alu_inst_type_out), 32'(eType));
    checkOutput("alu_vj", alu_vj_out, eVj);
    checkOutput("alu_vk", alu_vk_out, eVk);
    checkOutput("alu_A", alu_A_out, eA);
    checkOutput("alu_pc", alu_pc_out, ePc);
    checkOutput("alu_dest", 32'(alu_dest_out), 32'(eDest));
    checkOutput("rs_full", 32'(rs_full_out), 32'(modelFull()));
    setIdle();
  endtask

  task automatic doReset();
    rst_in = 0;
    #1;
    modelReset();
    checkOutput("rst_full", 32'(rs_full_out), 32'd0);
    checkOutput("rst_en", 32'(alu_en_out), 32'd0);
    checkOutput("rst_vj", alu_vj_out, 32'd0);
    checkOutput("rst_dest", 32'(alu_dest_out), 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1;
  endtask

  initial begin
    setIdle();
    rst_in = 1;
    modelReset();
    #2;
    doReset();

    // ADDI with ready operand issues one edge after dispatch, for one cycle
    setDispatch(6'd1, 32'd5, 4'd0, 32'd0, 4'd0, 32'd7, 4'd3, 32'h100);
    applyStimulus();
    checkOutput("addi_e1_en", 32'(alu_en_out), 32'd0);
    applyStimulus();
    checkOutput("addi_e2_en", 32'(alu_en_out), 32'd1);
    checkOutput("addi_vj", alu_vj_out, 32'd5);
    checkOutput("addi_A", alu_A_out, 32'd7);
    checkOutput("addi_dest", 32'(alu_dest_out), 32'd3);
    applyStimulus();
    checkOutput("addi_e3_en", 32'(alu_en_out), 32'd0);

    // ADD waiting on tag 4, woken by the ALU bus
    setDispatch(6'd2, 32'd0, 4'd4, 32'd9, 4'd0, 32'd0, 4'd5, 32'h104);
    applyStimulus();
    applyStimulus();
    cdb_alu_en_in = 1; cdb_alu_tag_in = 4'd4; cdb_alu_data_in = 32'h10;
    applyStimulus();
    checkOutput("add_wake_en", 32'(alu_en_out), 32'd0);
    applyStimulus();
    checkOutput("add_issue_en", 32'(alu_en_out), 32'd1);
    checkOutput("add_vj", alu_vj_out, 32'h10);
    checkOutput("add_vk", alu_vk_out, 32'd9);

    // Same-cycle bypass from the load/store bus
    setDispatch(6'd3, 32'd0, 4'd6, 32'd1, 4'd0, 32'd0, 4'd7, 32'h108);
    cdb_lsb_en_in = 1; cdb_lsb_tag_in = 4'd6; cdb_lsb_data_in = 32'hAB;
    applyStimulus();
    applyStimulus();
    checkOutput("byp_en", 32'(alu_en_out), 32'd1);
    checkOutput("byp_vj", alu_vj_out, 32'hAB);

    // Fill all entries on tag 2, drop an extra dispatch, then drain in order
    doReset();
    for (int i = 0; i < 16; i++) begin
      setDispatch(6'd4, 32'd0, 4'd2, 32'd0, 4'd0, 32'(i), 4'((i % 15) + 1), 32'(i));
      applyStimulus();
    end
    checkOutput("fill_full", 32'(rs_full_out), 32'd1);
    setDispatch(6'd5, 32'd1, 4'd0, 32'd1, 4'd0, 32'd0, 4'd9, 32'd100);
    applyStimulus();
    applyStimulus();
    checkOutput("drop_en", 32'(alu_en_out), 32'd0);
    cdb_alu_en_in = 1; cdb_alu_tag_in = 4'd2; cdb_alu_data_in = 32'h22;
    applyStimulus();
    for (int i = 0; i < 16; i++) begin
      applyStimulus();
      checkOutput("drain_en", 32'(alu_en_out), 32'd1);
      checkOutput("drain_order", alu_pc_out, 32'(i));
    end
    checkOutput("drain_full", 32'(rs_full_out), 32'd0);
    applyStimulus();
    checkOutput("drain_done", 32'(alu_en_out), 32'd0);

    // Flush beats a simultaneous dispatch and matching broadcast
    doReset();
    for (int i = 0; i < 3; i++) begin
      setDispatch(6'd6, 32'd0, 4'd5, 32'd0, 4'd0, 32'd0, 4'(i + 1), 32'(i));
      applyStimulus();
    end
    clear_in = 1;
    setDispatch(6'd7, 32'd3, 4'd0, 32'd3, 4'd0, 32'd0, 4'd8, 32'd50);
    cdb_alu_en_in = 1; cdb_alu_tag_in = 4'd5; cdb_alu_data_in = 32'h55;
    applyStimulus();
    checkOutput("clr_en", 32'(alu_en_out), 32'd0);
    cdb_alu_en_in = 1; cdb_alu_tag_in = 4'd5; cdb_alu_data_in = 32'h55;
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("clr_quiet", 32'(alu_en_out), 32'd0);
    end

    // Randomized traffic including stalls, flushes and bus collisions
    for (int n = 0; n < 3000; n++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      clear_in = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) < 6)
        setDispatch(6'($urandom), $urandom, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0,
                    $urandom, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0,
                    $urandom, 4'($urandom), $urandom);
      cdb_alu_en_in = ($urandom_range(0, 2) == 0);
      cdb_alu_tag_in = 4'($urandom);
      cdb_alu_data_in = $urandom;
      cdb_lsb_en_in = ($urandom_range(0, 2) == 0);
      cdb_lsb_tag_in = ($urandom_range(0, 3) == 0) ? cdb_alu_tag_in : 4'($urandom);
      cdb_lsb_data_in = $urandom;
      applyStimulus();
    end

    // Reset in the middle of activity with entries still pending
    for (int i = 0; i < 4; i++) begin
      setDispatch(6'd8, 32'd0, 4'd7, 32'd0, 4'd7, 32'd0, 4'd1, 32'(i));
      applyStimulus();
    end
    #2;
    doReset();
    for (int i = 0; i < 3; i++) begin
      cdb_alu_en_in = 1; cdb_alu_tag_in = 4'd7; cdb_alu_data_in = 32'h77;
      applyStimulus();
      checkOutput("mid_rst_en", 32'(alu_en_out), 32'd0);
      checkOutput("mid_rst_full", 32'(rs_full_out), 32'd0);
    end
    setDispatch(6'd9, 32'd4, 4'd0, 32'd4, 4'd0, 32'd0, 4'd2, 32'h200);
    applyStimulus();
    applyStimulus();
    checkOutput("post_rst_issue", 32'(alu_en_out), 32'd1);
    checkOutput("post_rst_pc", alu_pc_out, 32'h200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Receiving end of the dispatcher's ALU-bound path.
- Buffers non-load/store instructions dispatched with operand values or producer ROB tags (vj/qj, vk/qk).
- Snoops the two common data buses (ALU result, load/store result) to wake waiting operands.
- Issues one operand-complete instruction per cycle to the ALU. Sits between the dispatcher and the ALU; flushed on branch misprediction.

Parameters:
- RS_SIZE, 16, number of entries (power of two).
- ROB_W, 4, ROB tag width. Tag 0 = "no dependency"; ROB entries are numbered 1..2^ROB_W-1.
- TYPE_W, 6, instruction type code width.
- XLEN, 32, data/address width.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; 0 freezes all state.
- clear_in  input  1  misprediction flush, synchronous.
- dispatch_en_in  input  1  new entry valid this cycle.
- inst_type_in  input  TYPE_W  instruction type.
- vj_in  input  XLEN  rs1 value (valid when qj_in==0).
- qj_in  input  ROB_W  rs1 producer tag.
- vk_in  input  XLEN  rs2 value (valid when qk_in==0).
- qk_in  input  ROB_W  rs2 producer tag.
- A_in  input  XLEN  immediate.
- dest_in  input  ROB_W  destination ROB tag.
- pc_in  input  XLEN  instruction PC.
- rs_full_out  output  1  no free entry.
- cdb_alu_en_in  input  1  ALU broadcast valid.
- cdb_alu_tag_in  input  ROB_W  ALU broadcast tag.
- cdb_alu_data_in  input  XLEN  ALU broadcast value.
- cdb_lsb_en_in  input  1  load/store broadcast valid.
- cdb_lsb_tag_in  input  ROB_W  load/store broadcast tag.
- cdb_lsb_data_in  input  XLEN  load/store broadcast value.
- alu_en_out  output  1  issue valid, one cycle.
- alu_inst_type_out  output  TYPE_W  issued type.
- alu_vj_out  output  XLEN  issued rs1 value.
- alu_vk_out  output  XLEN  issued rs2 value.
- alu_A_out  output  XLEN  issued immediate.
- alu_pc_out  output  XLEN  issued PC.
- alu_dest_out  output  ROB_W  issued ROB tag.

Behaviour:
- Reset (rst_in=0, async):
  - All entries not busy.
  - All alu_* outputs are 0.
  - rs_full_out=0.
- rdy_in=0: no register updates; outputs hold their values.
- Priority at each edge (rdy_in=1): clear_in > {wakeup, issue, allocate}.
- clear_in=1:
  - Every entry is not busy at the next edge.
  - alu_en_out=0.
  - dispatch_en_in and both CDBs are ignored that cycle.
- Allocate:
  - On dispatch_en_in, write to the lowest-index free entry.
  - Same-cycle bypass: if qj_in (or qk_in) is nonzero and equals a valid CDB tag in the same cycle, store the CDB data and tag 0.
  - dispatch_en_in while full is ignored (protocol violation; the dispatcher must not do it).
- Wakeup:
  - For each busy entry with qj!=0: if it matches cdb_alu_tag_in (en=1), set vj=data and qj=0; otherwise test cdb_lsb_tag_in the same way. Same rule for qk/vk.
  - Tag 0 on either CDB never matches.
  - If both CDBs carry the same tag, the ALU bus wins.
- Issue:
  - Select the lowest-index busy entry with qj==0 and qk==0, judged on register state at the start of the cycle.
  - At the edge, register its fields into alu_*, set alu_en_out=1, and free the entry.
  - If no entry is ready, alu_en_out=0 (other alu_* hold).
  - At most one issue per cycle.
- Latency:
  - Entry dispatched ready at edge N: alu_en_out is visible after edge N+1 at the earliest.
  - Entry woken at edge N: issue at edge N+1 at the earliest.
  - No same-cycle wake-and-issue.
- Free slots: a slot freed by issue is reusable from the next cycle. Allocation in the same cycle uses only slots free at the start of the cycle.
- rs_full_out:
  - Combinational from the busy vector: 1 iff all RS_SIZE entries are busy.
  - Simultaneous issue does not lower it within that cycle.
- Ordering: strict lowest-index selection. No age fairness is guaranteed; starvation is bounded because the ROB is finite.

Test Plan:
- Reset with rst_in=0 mid-run, entries busy -> after release, rs_full_out=0, alu_en_out=0, no issue until a new dispatch.
- Dispatch ADDI, qj=0, vj=5, A=7, dest=3 at edge 1 -> edge 2: alu_en_out=1, vj=5, A=7, dest=3; edge 3: alu_en_out=0.
- Dispatch ADD qj=4, qk=0, vk=9; two cycles later cdb_alu tag=4 data=0x10 -> issue one edge after the broadcast with vj=0x10, vk=9.
- Dispatch with qj=6 while cdb_lsb broadcasts tag 6 data=0xAB in the same cycle -> issues next edge with vj=0xAB.
- Fill 16 entries all waiting on tag 2 -> rs_full_out=1; extra dispatch dropped. Broadcast tag 2 -> 16 consecutive issues in index order 0..15, then rs_full_out=0.
- 3 waiting entries, assert clear_in together with dispatch and a matching CDB -> all freed, alu_en_out=0, nothing issues afterwards.
